// File: rtl/rr_pkg.sv
// Shared types and helpers for the round-robin grant mux slice.
package rr_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } rr_state_e;

    localparam int RR_NUM_PORTS = 4;

    // Index width for n ports; a single port still needs one bit.
    function automatic int port_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_onehot_enc.sv
// One-hot to binary encoder; a multi-hot input resolves to its lowest set index.
module rr_onehot_enc
    import rr_pkg::*;
#(
    parameter int NUM_PORTS = RR_NUM_PORTS
) (
    input  logic [NUM_PORTS-1:0]         onehot_i,
    output logic [port_w(NUM_PORTS)-1:0] idx_o,
    output logic                         any_o
);

    localparam int IDX_W = port_w(NUM_PORTS);

    // Scan from the top so the lowest set bit is the last one written
    always_comb begin
        idx_o = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (onehot_i[i]) begin
                idx_o = IDX_W'(i);
            end else begin
                idx_o = idx_o;
            end
        end
    end

    assign any_o = |onehot_i;

endmodule

// File: rtl/rr_grant_mux.sv
// Locks onto the arbiter's winning port and forwards its packet through a registered output.
// Optional lock watchdog (TIMEOUT_CYC, timeout_o) is enabled by defining RR_MUX_TIMEOUT_EN.
module rr_grant_mux
    import rr_pkg::*;
#(
    parameter int NUM_PORTS = RR_NUM_PORTS,
    parameter int DATA_W    = 32
`ifdef RR_MUX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 16
`endif
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_PORTS-1:0]          req_valid_i,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_data_i,
    input  logic [NUM_PORTS-1:0]          req_last_i,
    output logic [NUM_PORTS-1:0]          req_ready_o,
    output logic [NUM_PORTS-1:0]          arb_req_o,
    input  logic [NUM_PORTS-1:0]          gnt_i,
    output logic                          out_valid_o,
    output logic [DATA_W-1:0]             out_data_o,
    output logic                          out_last_o,
    output logic [port_w(NUM_PORTS)-1:0]  out_port_o,
    input  logic                          out_ready_i,
    output logic                          busy_o
`ifdef RR_MUX_TIMEOUT_EN
    ,
    output logic                          timeout_o
`endif
);

    localparam int PORT_W = port_w(NUM_PORTS);

    rr_state_e             state_r;
    rr_state_e             state_s;
    logic [PORT_W-1:0]     sel_r;
    logic [PORT_W-1:0]     gnt_idx_s;
    logic                  gnt_any_s;
    logic [NUM_PORTS-1:0]  sel_oh_s;
    logic [NUM_PORTS-1:0]  ready_s;
    logic [NUM_PORTS-1:0]  arb_s;
    logic [DATA_W-1:0]     sel_data_s;
    logic                  sel_last_s;
    logic                  accept_s;
    logic                  tmo_s;

    logic                  out_valid_r;
    logic [DATA_W-1:0]     out_data_r;
    logic                  out_last_r;
    logic [PORT_W-1:0]     out_port_r;

    rr_onehot_enc #(
        .NUM_PORTS (NUM_PORTS)
    ) u_gnt_enc (
        .onehot_i (gnt_i),
        .idx_o    (gnt_idx_s),
        .any_o    (gnt_any_s)
    );

    // Locked-port decode: request parking and the single-port ready
    always_comb begin
        sel_oh_s        = '0;
        sel_oh_s[sel_r] = 1'b1;
        if (state_r == LOCK) begin
            arb_s = sel_oh_s;
            if (!out_valid_r || out_ready_i) begin
                ready_s = sel_oh_s;
            end else begin
                ready_s = '0;
            end
        end else begin
            arb_s   = req_valid_i;
            ready_s = '0;
        end
    end

    assign sel_data_s  = req_data_i[sel_r*DATA_W +: DATA_W];
    assign sel_last_s  = |(req_last_i & sel_oh_s);
    assign accept_s    = |(req_valid_i & ready_s);
    assign req_ready_o = ready_s;
    assign arb_req_o   = reset_n ? arb_s : '0;
    assign busy_o      = (state_r == LOCK);

    // Next-state: lock on any grant, release after the last beat or a watchdog expiry
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (gnt_any_s) begin
                    state_s = LOCK;
                end else begin
                    state_s = IDLE;
                end
            end
            LOCK: begin
                if (accept_s && sel_last_s) begin
                    state_s = IDLE;
                end else if (tmo_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = LOCK;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register and port capture on grant
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            sel_r   <= '0;
        end else begin
            state_r <= state_s;
            if (state_r == IDLE && gnt_any_s) begin
                sel_r <= gnt_idx_s;
            end
        end
    end

    // Output beat register: load on accept, otherwise drain on downstream ready
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
            out_port_r  <= '0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= sel_data_s;
            out_last_r  <= sel_last_s;
            out_port_r  <= sel_r;
        end else if (out_ready_i) begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_valid_o = out_valid_r;
    assign out_data_o  = out_data_r;
    assign out_last_o  = out_last_r;
    assign out_port_o  = out_port_r;

`ifdef RR_MUX_TIMEOUT_EN
    localparam int CNT_W = port_w(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt_r;
    logic             timeout_r;

    assign tmo_s = (state_r == LOCK) && !accept_s && (cnt_r == CNT_W'(TIMEOUT_CYC - 1));

    // Watchdog counts idle LOCK cycles; cleared by any accept and outside LOCK
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r     <= '0;
            timeout_r <= 1'b0;
        end else begin
            if (state_r != LOCK || accept_s || tmo_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            timeout_r <= tmo_s;
        end
    end

    assign timeout_o = timeout_r;
`else
    assign tmo_s = 1'b0;
`endif

endmodule
